// File: rtl/signal_tracker.sv
// History recorder for one sampled signal. Two independent engines query it:
// earliest assertion time inside a look-back window, and the value from M cycles ago.
module signal_tracker #(
    parameter int WIDTH              = 1,
    parameter int SIGNAL_BUFFER_SIZE = 256,
    parameter int COUNTER_WIDTH      = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [COUNTER_WIDTH-1:0] counter,
    input  logic [WIDTH-1:0]         signal_in,
    input  logic                     tt_recalculate,
    input  logic [COUNTER_WIDTH-1:0] tt_lookback,
    input  logic                     tt_prev_end_update,
    input  logic [COUNTER_WIDTH-1:0] tt_new_prev_end,
    output logic [COUNTER_WIDTH-1:0] tt_time_out,
    output logic                     tt_data_valid,
    input  logic                     vf_recalculate,
    input  logic [COUNTER_WIDTH-1:0] vf_cycles_back,
    output logic [WIDTH-1:0]         vf_signal_recall,
    output logic                     vf_hit,
    output logic                     vf_data_valid
);
    localparam int AW         = $clog2(SIGNAL_BUFFER_SIZE);
    localparam int CW         = COUNTER_WIDTH;
    localparam int EW         = CW + WIDTH;
    localparam int SPAN_MAX_I = SIGNAL_BUFFER_SIZE - 2;
    localparam logic [AW:0]   SIZE_C   = SIGNAL_BUFFER_SIZE[AW:0];
    localparam logic [AW:0]   SPAN_MAX = SPAN_MAX_I[AW:0];
    localparam logic [CW-1:0] SIZE_W   = CW'(SIGNAL_BUFFER_SIZE);

    localparam logic [1:0] TT_IDLE = 2'd0;
    localparam logic [1:0] TT_SCAN = 2'd1;
    localparam logic [1:0] TT_DONE = 2'd2;
    localparam logic [0:0] VF_IDLE = 1'b0;
    localparam logic [0:0] VF_DONE = 1'b1;

    // Each entry is {time, value}; only entries within count_q are ever read.
    logic [EW-1:0]        mem_q [SIGNAL_BUFFER_SIZE];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW:0]          count_q, count_d;
    logic signed [CW-1:0] prev_end_q, prev_end_d;

    logic [1:0]    tt_state_q, tt_state_d;
    logic [AW-1:0] tt_ptr_q, tt_ptr_d;
    logic [AW:0]   tt_left_q, tt_left_d;
    logic [CW-1:0] tt_time_q, tt_time_d;
    logic          tt_valid_q, tt_valid_d;

    logic [0:0]       vf_state_q, vf_state_d;
    logic [WIDTH-1:0] vf_recall_q, vf_recall_d;
    logic             vf_hit_q, vf_hit_d;
    logic             vf_valid_q, vf_valid_d;

    logic [CW-1:0]    tt_n;
    logic [AW:0]      tt_span, tt_lim, tt_len;
    logic [EW-1:0]    tt_entry;
    logic [CW-1:0]    tt_e_time;
    logic [WIDTH-1:0] tt_e_val;
    logic             tt_match;
    logic [CW-1:0]    vf_m;
    logic [AW-1:0]    vf_idx;
    logic [WIDTH-1:0] vf_rd_val;
    logic             vf_in_hist;

    always_comb begin
        wr_ptr_d   = wr_ptr_q + 1'b1;
        count_d    = (count_q == SIZE_C) ? count_q : count_q + 1'b1;
        prev_end_d = tt_prev_end_update ? $signed(tt_new_prev_end) : prev_end_q;
    end

    // Window is capped at SIZE-2 so the oldest scanned entry survives the writes made while scanning.
    always_comb begin
        tt_n      = tt_lookback[CW-1] ? '0 : tt_lookback;
        tt_span   = (count_q == SIZE_C) ? SIZE_C - 1'b1 : count_q;
        tt_lim    = (tt_span < SPAN_MAX) ? tt_span : SPAN_MAX;
        tt_len    = (tt_n < CW'(tt_lim)) ? tt_n[AW:0] : tt_lim;
        tt_entry  = mem_q[tt_ptr_q];
        tt_e_time = tt_entry[EW-1:WIDTH];
        tt_e_val  = tt_entry[WIDTH-1:0];
        tt_match  = (tt_e_val != '0) && ($signed(tt_e_time) > prev_end_q);
    end

    always_comb begin
        tt_state_d = tt_state_q;
        tt_ptr_d   = tt_ptr_q;
        tt_left_d  = tt_left_q;
        tt_time_d  = tt_time_q;
        tt_valid_d = tt_valid_q;
        case (tt_state_q)
            TT_IDLE: begin
                if (tt_recalculate) begin
                    if (tt_len == '0) begin
                        tt_time_d  = '1;
                        tt_valid_d = 1'b1;
                        tt_state_d = TT_DONE;
                    end else begin
                        tt_ptr_d   = wr_ptr_q - tt_len[AW-1:0];
                        tt_left_d  = tt_len - 1'b1;
                        tt_state_d = TT_SCAN;
                    end
                end
            end
            TT_SCAN: begin
                if (tt_match) begin
                    tt_time_d  = tt_e_time;
                    tt_valid_d = 1'b1;
                    tt_state_d = TT_DONE;
                end else if (tt_left_q == '0) begin
                    tt_time_d  = '1;
                    tt_valid_d = 1'b1;
                    tt_state_d = TT_DONE;
                end else begin
                    tt_ptr_d  = tt_ptr_q + 1'b1;
                    tt_left_d = tt_left_q - 1'b1;
                end
            end
            TT_DONE: begin
                if (!tt_recalculate) begin
                    tt_valid_d = 1'b0;
                    tt_state_d = TT_IDLE;
                end
            end
            default: tt_state_d = TT_IDLE;
        endcase
    end

    // The entry written M cycles before the request sits M slots behind the write pointer.
    always_comb begin
        vf_m       = vf_cycles_back[CW-1] ? '0 : vf_cycles_back;
        vf_idx     = wr_ptr_q - vf_m[AW-1:0];
        vf_rd_val  = mem_q[vf_idx][WIDTH-1:0];
        vf_in_hist = (vf_m <= CW'(count_q)) && (vf_m < SIZE_W);
    end

    always_comb begin
        vf_state_d  = vf_state_q;
        vf_recall_d = vf_recall_q;
        vf_hit_d    = vf_hit_q;
        vf_valid_d  = vf_valid_q;
        case (vf_state_q)
            VF_IDLE: begin
                if (vf_recalculate) begin
                    vf_valid_d = 1'b1;
                    vf_state_d = VF_DONE;
                    if (vf_m == '0) begin
                        vf_recall_d = signal_in;
                        vf_hit_d    = 1'b1;
                    end else if (vf_in_hist) begin
                        vf_recall_d = vf_rd_val;
                        vf_hit_d    = 1'b1;
                    end else begin
                        vf_recall_d = '0;
                        vf_hit_d    = 1'b0;
                    end
                end
            end
            default: begin
                if (!vf_recalculate) begin
                    vf_valid_d = 1'b0;
                    vf_state_d = VF_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) mem_q[wr_ptr_q] <= {counter, signal_in};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            count_q     <= '0;
            prev_end_q  <= '1;
            tt_state_q  <= TT_IDLE;
            tt_ptr_q    <= '0;
            tt_left_q   <= '0;
            tt_time_q   <= '1;
            tt_valid_q  <= 1'b0;
            vf_state_q  <= VF_IDLE;
            vf_recall_q <= '0;
            vf_hit_q    <= 1'b0;
            vf_valid_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            prev_end_q  <= prev_end_d;
            tt_state_q  <= tt_state_d;
            tt_ptr_q    <= tt_ptr_d;
            tt_left_q   <= tt_left_d;
            tt_time_q   <= tt_time_d;
            tt_valid_q  <= tt_valid_d;
            vf_state_q  <= vf_state_d;
            vf_recall_q <= vf_recall_d;
            vf_hit_q    <= vf_hit_d;
            vf_valid_q  <= vf_valid_d;
        end
    end

    assign tt_time_out      = tt_time_q;
    assign tt_data_valid    = tt_valid_q;
    assign vf_signal_recall = vf_recall_q;
    assign vf_hit           = vf_hit_q;
    assign vf_data_valid    = vf_valid_q;

endmodule

// File: tb/tb_signal_tracker.sv
// Bench for signal_tracker: constant-vector table on a fixed history, hand-written
// mid-scan sequences, and random requests checked against a queue-based history model.
module tb_signal_tracker;
    localparam int W  = 8;
    localparam int SZ = 16;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] counter = '0;
    logic [W-1:0]  signal_in = '0;
    logic          tt_recalculate = 1'b0;
    logic [CW-1:0] tt_lookback = '0;
    logic          tt_prev_end_update = 1'b0;
    logic [CW-1:0] tt_new_prev_end = '0;
    logic [CW-1:0] tt_time_out;
    logic          tt_data_valid;
    logic          vf_recalculate = 1'b0;
    logic [CW-1:0] vf_cycles_back = '0;
    logic [W-1:0]  vf_signal_recall;
    logic          vf_hit;
    logic          vf_data_valid;

    always #5 clk = ~clk;

    signal_tracker #(.WIDTH(W), .SIGNAL_BUFFER_SIZE(SZ), .COUNTER_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .counter(counter), .signal_in(signal_in),
        .tt_recalculate(tt_recalculate), .tt_lookback(tt_lookback),
        .tt_prev_end_update(tt_prev_end_update), .tt_new_prev_end(tt_new_prev_end),
        .tt_time_out(tt_time_out), .tt_data_valid(tt_data_valid),
        .vf_recalculate(vf_recalculate), .vf_cycles_back(vf_cycles_back),
        .vf_signal_recall(vf_signal_recall), .vf_hit(vf_hit), .vf_data_valid(vf_data_valid)
    );

    typedef struct { int t; int v; } ent_t;
    typedef struct { int n; int pe; int m; int t; int tlat; bit exact; int r; int h; } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    ent_t hist[$];
    int   total = 0;
    int   pe_m  = -1;

    task automatic chk(string nm, bit ok, int act, int exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rsig();
        return ($urandom_range(0, 3) == 0) ? W'($urandom_range(1, 255)) : '0;
    endfunction

    // One clock: the model records what the DUT samples at this edge.
    task automatic step();
        if (rst_n) begin
            hist.push_back('{t: $signed(counter), v: int'(signal_in)});
            total++;
            if (hist.size() > 40) void'(hist.pop_front());
            if (tt_prev_end_update) pe_m = $signed(tt_new_prev_end);
        end else begin
            hist.delete();
            total = 0;
            pe_m  = -1;
        end
        @(posedge clk);
        #1;
        counter = counter + 1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tt_recalculate = 1'b0;
        vf_recalculate = 1'b0;
        tt_prev_end_update = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Pulses at 10, 20, 23; prev_end loaded on the last cycle; next cycle (counter 25) is the request.
    task automatic build_hist(int pe);
        do_reset();
        counter = 10;
        for (int c = 10; c <= 24; c++) begin
            signal_in = (c == 10) ? 8'h33 : (c == 20) ? 8'hA5 : (c == 23) ? 8'h01 : 8'h00;
            tt_prev_end_update = (c == 24);
            tt_new_prev_end = pe;
            step();
        end
        tt_prev_end_update = 1'b0;
    endtask

    task automatic run_req(string nm, int n, int m, logic [W-1:0] sig, int upd_at, int upd_val,
                           int exp_t, int tlat, bit exact, int exp_r, int exp_h);
        int tl = 0;
        int vl = 0;
        int t_got = 0;
        int r_got = 0;
        int h_got = 0;
        signal_in = sig;
        tt_prev_end_update = 1'b0;
        tt_recalculate = 1'b1;
        tt_lookback = n;
        vf_recalculate = 1'b1;
        vf_cycles_back = m;
        for (int k = 1; k <= 40 && (tl == 0 || vl == 0); k++) begin
            step();
            signal_in = rsig();
            tt_lookback = $urandom_range(0, 50);
            tt_prev_end_update = (k == upd_at);
            tt_new_prev_end = upd_val;
            if (tl == 0 && tt_data_valid) begin
                tl = k;
                t_got = $signed(tt_time_out);
            end
            if (vl == 0 && vf_data_valid) begin
                vl = k;
                r_got = int'(vf_signal_recall);
                h_got = int'(vf_hit);
            end
        end
        tt_prev_end_update = 1'b0;
        if (tl == 0) chk({nm, " tt_timeout"}, 1'b0, 0, 1);
        else begin
            chk({nm, " tt_time"}, t_got == exp_t, t_got, exp_t);
            if (exact) chk({nm, " tt_lat"}, tl == tlat, tl, tlat);
            else chk({nm, " tt_lat_max"}, tl <= tlat, tl, tlat);
        end
        if (vl == 0) chk({nm, " vf_timeout"}, 1'b0, 0, 1);
        else begin
            chk({nm, " vf_lat"}, vl == 1, vl, 1);
            chk({nm, " vf_recall"}, r_got == exp_r, r_got, exp_r);
            chk({nm, " vf_hit"}, h_got == exp_h, h_got, exp_h);
        end
        chk({nm, " vf_hold"}, vf_data_valid && int'(vf_signal_recall) == exp_r,
            int'(vf_signal_recall), exp_r);
        chk({nm, " tt_hold"}, tt_data_valid && $signed(tt_time_out) == exp_t,
            $signed(tt_time_out), exp_t);
        tt_recalculate = 1'b0;
        vf_recalculate = 1'b0;
        step();
        chk({nm, " tt_clear"}, !tt_data_valid, int'(tt_data_valid), 0);
        chk({nm, " vf_clear"}, !vf_data_valid, int'(vf_data_valid), 0);
    endtask

    task automatic model_req(int n, int m, logic [W-1:0] sig, output int t, output int lat,
                             output bit exact, output int r, output int h);
        int cnt = (total + 1 < SZ) ? total + 1 : SZ;
        int len = (n < 0) ? 0 : n;
        int mm  = (m < 0) ? 0 : m;
        int avail = (total < SZ) ? total : SZ;
        if (len > cnt - 1) len = cnt - 1;
        if (len > SZ - 2) len = SZ - 2;
        t = -1;
        lat = len + 1;
        exact = 1'b1;
        for (int i = hist.size() - len; i < hist.size(); i++) begin
            if (hist[i].v != 0 && hist[i].t > pe_m) begin
                t = hist[i].t;
                exact = 1'b0;
                break;
            end
        end
        if (mm == 0) begin r = int'(sig); h = 1; end
        else if (mm <= avail && mm < SZ) begin r = hist[hist.size() - mm].v; h = 1; end
        else begin r = 0; h = 0; end
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{n: 8,   pe: -1, m: 0,  t: 20, tlat: 9,  exact: 0, r: 8'h7E, h: 1};
        vecs[1]  = '{n: 8,   pe: 21, m: 2,  t: 23, tlat: 9,  exact: 0, r: 8'h01, h: 1};
        vecs[2]  = '{n: 8,   pe: 23, m: 5,  t: -1, tlat: 9,  exact: 1, r: 8'hA5, h: 1};
        vecs[3]  = '{n: 2,   pe: -1, m: 15, t: 23, tlat: 3,  exact: 0, r: 8'h33, h: 1};
        vecs[4]  = '{n: 1,   pe: -1, m: 16, t: -1, tlat: 2,  exact: 1, r: 0,     h: 0};
        vecs[5]  = '{n: 0,   pe: -1, m: -1, t: -1, tlat: 1,  exact: 1, r: 8'h7E, h: 1};
        vecs[6]  = '{n: 5,   pe: -1, m: 1,  t: 20, tlat: 6,  exact: 0, r: 0,     h: 1};
        vecs[7]  = '{n: 4,   pe: -1, m: 20, t: 23, tlat: 5,  exact: 0, r: 0,     h: 0};
        vecs[8]  = '{n: 100, pe: -1, m: 14, t: 20, tlat: 15, exact: 0, r: 0,     h: 1};
        vecs[9]  = '{n: 100, pe: 23, m: 3,  t: -1, tlat: 15, exact: 1, r: 0,     h: 1};
        vecs[10] = '{n: -3,  pe: -1, m: 9,  t: -1, tlat: 1,  exact: 1, r: 0,     h: 1};
        vecs[11] = '{n: 8,   pe: -1, m: 5,  t: 20, tlat: 9,  exact: 0, r: 8'hA5, h: 1};

        do_reset();
        chk("reset tt_time", $signed(tt_time_out) == -1, $signed(tt_time_out), -1);
        chk("reset tt_valid", !tt_data_valid, int'(tt_data_valid), 0);
        chk("reset vf_recall", vf_signal_recall == '0, int'(vf_signal_recall), 0);
        chk("reset vf_hit", !vf_hit, int'(vf_hit), 0);
        chk("reset vf_valid", !vf_data_valid, int'(vf_data_valid), 0);

        // Ten quiet cycles, then a 5-cycle window that must miss after 6 cycles.
        counter = 2;
        signal_in = '0;
        for (int i = 0; i < 10; i++) step();
        run_req("quiet", 5, 11, 8'h00, 0, 0, -1, 6, 1'b1, 0, 0);

        foreach (vecs[i]) begin
            build_hist(vecs[i].pe);
            run_req($sformatf("vec%0d", i), vecs[i].n, vecs[i].m, 8'h7E, 0, 0,
                    vecs[i].t, vecs[i].tlat, vecs[i].exact, vecs[i].r, vecs[i].h);
        end

        // prev_end loaded during the scan hides the pulse at 20 but not the one at 23.
        build_hist(-1);
        run_req("pe_midscan", 8, 5, 8'h7E, 1, 21, 23, 9, 1'b0, 8'hA5, 1);

        // Reset in the middle of a scan aborts it; later requests see only new history.
        build_hist(-1);
        run_req("pre_rst", 8, 5, 8'h7E, 0, 0, 20, 9, 1'b0, 8'hA5, 1);
        tt_prev_end_update = 1'b1;
        tt_new_prev_end = 1000;
        step();
        tt_prev_end_update = 1'b0;
        tt_recalculate = 1'b1;
        tt_lookback = 8;
        for (int i = 0; i < 3; i++) step();
        rst_n = 1'b0;
        tt_recalculate = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst tt_valid", !tt_data_valid, int'(tt_data_valid), 0);
            chk("rst tt_time", $signed(tt_time_out) == -1, $signed(tt_time_out), -1);
            chk("rst vf_hit", !vf_hit && vf_signal_recall == '0, int'(vf_signal_recall), 0);
        end
        rst_n = 1'b1;
        signal_in = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst tt_valid", !tt_data_valid, int'(tt_data_valid), 0);
        end
        run_req("post_rst", 8, 4, 8'h11, 0, 0, -1, 4, 1'b1, 0, 0);

        // Random requests against the history model.
        do_reset();
        counter = 1000;
        for (int i = 0; i < 12; i++) begin
            signal_in = rsig();
            step();
        end
        for (int tr = 0; tr < 30; tr++) begin
            int n, m, et, el, er, eh;
            bit ex;
            logic [W-1:0] s;
            int idle = $urandom_range(0, 6);
            for (int i = 0; i < idle; i++) begin
                signal_in = rsig();
                tt_prev_end_update = ($urandom_range(0, 4) == 0);
                tt_new_prev_end = ($urandom_range(0, 3) == 0) ? -1 :
                                  $signed(counter) - $urandom_range(0, 12);
                step();
            end
            tt_prev_end_update = 1'b0;
            n = $urandom_range(0, 22) - 2;
            m = $urandom_range(0, 21) - 1;
            s = rsig();
            model_req(n, m, s, et, el, ex, er, eh);
            run_req($sformatf("rnd%0d", tr), n, m, s, 0, 0, et, el, ex, er, eh);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/signal_tracker.md
Name: signal_tracker

Overview:
- Cycle-accurate history recorder for one sampled signal, with two query engines over the recorded history.
- Time-test engine: finds the earliest recorded cycle in which the signal was asserted inside a look-back window.
- Value-find engine: returns the signal value from N cycles ago.
- Used by the pipeline trace trackers (EX tracker) to reconstruct memory-request, rvalid and address timing after an instruction leaves decode.

Parameters:
- WIDTH, 1, bit width of the tracked signal.
- SIGNAL_BUFFER_SIZE, 256, number of history entries (power of two, ≥4).
- COUNTER_WIDTH, 32, width of the global cycle counter and of all time values (signed).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- counter  in  COUNTER_WIDTH  global cycle counter, increments by 1 per cycle.
- signal_in  in  WIDTH  tracked signal.
- tt_recalculate  in  1  level request for a time-test search.
- tt_lookback  in  COUNTER_WIDTH  window length N in cycles back from the request cycle.
- tt_prev_end_update  in  1  load tt_new_prev_end into the previous-end register.
- tt_new_prev_end  in  COUNTER_WIDTH  new previous-end time.
- tt_time_out  out  COUNTER_WIDTH  signed; found time, or -1 if none.
- tt_data_valid  out  1  tt_time_out valid.
- vf_recalculate  in  1  level request for a value recall.
- vf_cycles_back  in  COUNTER_WIDTH  cycles back M (0 = current cycle).
- vf_signal_recall  out  WIDTH  recalled value.
- vf_hit  out  1  M was within recorded history.
- vf_data_valid  out  1  vf outputs valid.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - wr_ptr=0, entry count=0, prev_end=-1.
  - Both engines go IDLE.
  - tt_time_out=-1, tt_data_valid=0, vf_signal_recall=0, vf_hit=0, vf_data_valid=0.
  - Reset mid-search aborts the search with no result.
- Recording: every non-reset cycle, write {counter, signal_in} at wr_ptr, wr_ptr=(wr_ptr+1) mod SIZE, count saturates at SIZE. The oldest entry is overwritten when full.
- "Asserted" means signal_in != 0.
- prev_end: loaded from tt_new_prev_end on any cycle tt_prev_end_update=1. Takes effect for entries compared from the next cycle, including a search already in progress.
- Time-test FSM, states IDLE, SCAN, DONE:
  - IDLE→SCAN on tt_recalculate=1. Capture req_time=counter.
  - Window start = req_time - min(N, count-1, SIZE-2). Scan pointer = entry holding that time.
  - SCAN examines one entry per cycle, oldest to newest. Stop at the first entry with value asserted and time > prev_end: tt_time_out=that time, go DONE.
  - Reaching the entry for req_time-1 with no hit gives tt_time_out=-1, go DONE.
  - The request cycle itself is excluded; the caller checks the live signal.
  - Latency = window length + 1 cycles, max SIZE-1.
  - DONE: tt_data_valid=1, outputs held stable. When tt_recalculate=0, clear tt_data_valid next cycle and go IDLE.
  - tt_recalculate toggles or changes of tt_lookback while in SCAN are ignored.
  - N=0 gives an immediate -1 on the cycle after the request.
- Value-find FSM, states IDLE, DONE:
  - On vf_recalculate=1 in IDLE, the next cycle drives vf_data_valid=1.
  - M=0: vf_signal_recall = signal_in sampled on the request cycle, vf_hit=1.
  - 1≤M≤count: recall the entry written M cycles before the request, vf_hit=1.
  - M>count or M≥SIZE: vf_signal_recall=0, vf_hit=0.
  - DONE holds until vf_recalculate=0, then clears vf_data_valid next cycle.
- Engines are independent and may run simultaneously.
- Recording never stalls.
- Negative tt_lookback or vf_cycles_back is treated as 0.

Test Plan:
- Reset, then 10 cycles with signal_in=0; tt_lookback=5 → tt_data_valid after 6 cycles, tt_time_out=-1; drop request → tt_data_valid=0 next cycle.
- signal_in=1 at counter 20 and 23; request at counter 25, N=8, prev_end=-1 → tt_time_out=20.
- Same history with tt_prev_end_update loading 21 → tt_time_out=23. With 23 loaded → -1.
- signal_in=8'hA5 (WIDTH=8) at counter 40; vf request at counter 43, M=3 → vf_signal_recall=8'hA5, vf_hit=1, vf_data_valid one cycle later.
- SIZE=16: run 40 cycles, M=20 → vf_hit=0, recall 0. Time test with N=100 → window clipped to 14 cycles.
- Assert rst_n=0 during a SCAN → tt_data_valid stays 0, tt_time_out=-1. A post-reset request sees no pre-reset history.
